// File: rtl/top.sv
// Bingo-style game: keypad card entry into a 16-entry memory, then LFSR/hack draws marked against both player cards.
// Keys register after DEBOUNCE_COUNT stable cycles; a draw takes 1 + 16 + HOLD_COUNT cycles and next edges outside IDLE are dropped.
module top #(
  parameter int DEBOUNCE_COUNT = 100000,
  parameter int HOLD_COUNT     = 50000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [2:0] keyboard_cols,
  input  logic [7:0] hack_number,
  input  logic       load_hack,
  input  logic       player_sel,
  input  logic       next,
  output logic [3:0] keyboard_rows,
  output logic [7:0] selcted_number,
  output logic [7:0] output_number
);

  localparam int DB_W = $clog2(DEBOUNCE_COUNT + 1);
  localparam int HD_W = $clog2(HOLD_COUNT + 1);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_IDLE  = 3'd1,
    S_DRAW  = 3'd2,
    S_SCAN  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // keypad scan / debounce
  logic [2:0]      cols_q;
  logic [DB_W-1:0] db_cnt;
  logic            key_down;
  logic            key_vld;
  logic [3:0]      key_dat;
  logic [3:0]      key_code;
  logic [3:0]      col_idx;
  logic            db_cond;
  logic            db_done;

  // entry and game state
  logic [7:0]      mem [16];
  logic [4:0]      wr_ptr;
  logic [3:0]      d1, d2;
  logic            have_d1;
  logic            commit;
  logic            start_game;
  logic [15:0]     game_state;
  logic            endgame;
  logic [3:0]      scan_idx;
  logic [HD_W-1:0] hold_cnt;
  logic            hold_done;
  logic            next_q, next_qq;
  logic            next_rise;
  logic [7:0]      lfsr;
  logic            lfsr_fb;
  logic [7:0]      draw_val;

  function automatic logic [3:0] bcd_fix(input logic [3:0] n);
    return (n >= 4'd10) ? n - 4'd6 : n;
  endfunction

  always_comb begin
    col_idx = keyboard_cols[2] ? 4'd0 : (keyboard_cols[1] ? 4'd1 : 4'd2);
    key_code = 4'hF;
    case (keyboard_rows)
      4'b1000: key_code = 4'd1 + col_idx;
      4'b0100: key_code = 4'd4 + col_idx;
      4'b0010: key_code = 4'd7 + col_idx;
      4'b0001: key_code = (col_idx == 4'd0) ? 4'hA : ((col_idx == 4'd1) ? 4'h0 : 4'hB);
      default: key_code = 4'hF;
    endcase
  end

  // press needs stable non-zero cols, release needs stable zero cols
  assign db_cond = (keyboard_cols == cols_q) &&
                   (key_down ? (keyboard_cols == 3'b000) : (keyboard_cols != 3'b000));
  assign db_done = db_cond && (db_cnt == DB_W'(DEBOUNCE_COUNT - 1));

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      keyboard_rows <= 4'b1000;
      cols_q        <= 3'b000;
      db_cnt        <= '0;
      key_down      <= 1'b0;
      key_vld       <= 1'b0;
      key_dat       <= 4'h0;
    end else begin
      cols_q  <= keyboard_cols;
      key_vld <= 1'b0;
      if (keyboard_cols == 3'b000)
        keyboard_rows <= {keyboard_rows[0], keyboard_rows[3:1]};
      if (!db_cond) begin
        db_cnt <= '0;
      end else if (db_done) begin
        db_cnt   <= '0;
        key_down <= !key_down;
        if (!key_down) begin
          key_vld <= 1'b1;
          key_dat <= key_code;
        end
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign draw_val  = load_hack ? hack_number : {bcd_fix(lfsr[7:4]), bcd_fix(lfsr[3:0])};
  assign next_rise = next_q && !next_qq;
  assign hold_done = (hold_cnt == HD_W'(HOLD_COUNT - 1));

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) state <= S_START;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_START: if (start_game)              state_nxt = S_IDLE;
      S_IDLE:  if (next_rise && !endgame)   state_nxt = S_DRAW;
      S_DRAW:                               state_nxt = S_SCAN;
      S_SCAN:  if (scan_idx == 4'd15)       state_nxt = S_HOLD;
      S_HOLD:  if (hold_done)               state_nxt = S_IDLE;
      default:                              state_nxt = S_START;
    endcase
  end

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h00;
      wr_ptr        <= 5'd0;
      d1            <= 4'h0;
      d2            <= 4'h0;
      have_d1       <= 1'b0;
      commit        <= 1'b0;
      start_game    <= 1'b0;
      game_state    <= 16'h0000;
      endgame       <= 1'b0;
      scan_idx      <= 4'd0;
      hold_cnt      <= '0;
      next_q        <= 1'b0;
      next_qq       <= 1'b0;
      lfsr          <= 8'h01;
      output_number <= 8'h00;
    end else begin
      lfsr    <= {lfsr[6:0], lfsr_fb};
      next_q  <= next;
      next_qq <= next_q;
      commit  <= 1'b0;

      if (key_vld && !start_game) begin
        if (key_dat <= 4'd9) begin
          if (wr_ptr != 5'd16) begin
            if (!have_d1) begin
              d1      <= key_dat;
              have_d1 <= 1'b1;
            end else begin
              d2     <= key_dat;
              commit <= 1'b1;
            end
          end
        end else if (key_dat == 4'hA) begin
          d1      <= 4'h0;
          d2      <= 4'h0;
          have_d1 <= 1'b0;
        end else if (key_dat == 4'hB) begin
          if (wr_ptr == 5'd16) start_game <= 1'b1;
        end
      end

      // second digit is latched first so {d1,d2} is visible for a cycle before it lands in memory
      if (commit) begin
        mem[wr_ptr[3:0]] <= {d1, d2};
        wr_ptr           <= wr_ptr + 5'd1;
        d1               <= 4'h0;
        d2               <= 4'h0;
        have_d1          <= 1'b0;
      end

      case (state)
        S_DRAW: begin
          output_number <= draw_val;
          scan_idx      <= 4'd0;
        end
        S_SCAN: begin
          if (mem[scan_idx] == output_number && !game_state[scan_idx]) begin
            mem[scan_idx]        <= 8'h00;
            game_state[scan_idx] <= 1'b1;
          end
          scan_idx <= scan_idx + 4'd1;
        end
        S_HOLD: begin
          hold_cnt <= hold_done ? '0 : hold_cnt + 1'b1;
          if (hold_done && ((&game_state[7:0]) || (&game_state[15:8])))
            endgame <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign selcted_number = start_game ? (player_sel ? game_state[15:8] : game_state[7:0])
                                     : {d1, d2};

endmodule

// File: tb/tb_top.sv
// Randomized bench for top: keypad card entry, hack draws with random misses, endgame and reset, against a card-level model.
module tb_top;

  logic       clk = 1'b0;
  logic       rstn;
  logic [2:0] keyboard_cols;
  logic [7:0] hack_number;
  logic       load_hack;
  logic       player_sel;
  logic       next;
  logic [3:0] keyboard_rows;
  logic [7:0] selcted_number;
  logic [7:0] output_number;

  logic       key_on;
  logic [3:0] key_row;
  logic [2:0] key_col;

  int total = 0;
  int bad   = 0;

  // card-level model
  logic [7:0]  m_mem [16];
  int          m_wp;
  logic [3:0]  m_d1;
  bit          m_have;
  bit          m_started;
  bit          m_end;
  logic [15:0] m_gs;
  logic [7:0]  m_out;

  // physical keypad: a held key closes its column only while its row is driven
  assign keyboard_cols = (key_on && keyboard_rows == key_row) ? key_col : 3'b000;

  top #(.DEBOUNCE_COUNT(20), .HOLD_COUNT(50)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .keyboard_cols (keyboard_cols),
    .hack_number   (hack_number),
    .load_hack     (load_hack),
    .player_sel    (player_sel),
    .next          (next),
    .keyboard_rows (keyboard_rows),
    .selcted_number(selcted_number),
    .output_number (output_number)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_wp = 0; m_d1 = 4'h0; m_have = 0; m_started = 0; m_end = 0;
    m_gs = 16'h0000; m_out = 8'h00;
  endtask

  task automatic model_key(input int code);
    if (m_started) return;
    if (code <= 9) begin
      if (m_wp < 16) begin
        if (!m_have) begin
          m_d1 = 4'(code); m_have = 1;
        end else begin
          m_mem[m_wp] = {m_d1, 4'(code)};
          m_wp++; m_d1 = 4'h0; m_have = 0;
        end
      end
    end else if (code == 10) begin
      m_d1 = 4'h0; m_have = 0;
    end else if (code == 11 && m_wp == 16) begin
      m_started = 1;
    end
  endtask

  task automatic model_draw(input logic [7:0] v);
    if (!m_started || m_end) return;
    m_out = v;
    for (int i = 0; i < 16; i++)
      if (m_mem[i] == v && !m_gs[i]) begin
        m_mem[i] = 8'h00; m_gs[i] = 1'b1;
      end
    if (m_gs[7:0] == 8'hFF || m_gs[15:8] == 8'hFF) m_end = 1;
  endtask

  function automatic logic [7:0] exp_sel();
    if (m_started) return player_sel ? m_gs[15:8] : m_gs[7:0];
    return {m_d1, 4'h0};
  endfunction

  task automatic press(input int code);
    case (code)
      1: begin key_row = 4'b1000; key_col = 3'b100; end
      2: begin key_row = 4'b1000; key_col = 3'b010; end
      3: begin key_row = 4'b1000; key_col = 3'b001; end
      4: begin key_row = 4'b0100; key_col = 3'b100; end
      5: begin key_row = 4'b0100; key_col = 3'b010; end
      6: begin key_row = 4'b0100; key_col = 3'b001; end
      7: begin key_row = 4'b0010; key_col = 3'b100; end
      8: begin key_row = 4'b0010; key_col = 3'b010; end
      9: begin key_row = 4'b0010; key_col = 3'b001; end
      0: begin key_row = 4'b0001; key_col = 3'b010; end
      10: begin key_row = 4'b0001; key_col = 3'b100; end
      default: begin key_row = 4'b0001; key_col = 3'b001; end
    endcase
    key_on = 1'b1;
    repeat (300) @(negedge clk);
    key_on = 1'b0;
    repeat (300) @(negedge clk);
    model_key(code);
  endtask

  task automatic draw(input logic [7:0] v);
    hack_number = v;
    load_hack   = 1'b1;
    next        = 1'b1;
    repeat (3) @(negedge clk);
    next = 1'b0;
    repeat (100) @(negedge clk);
    model_draw(v);
  endtask

  task automatic check_outputs(input string tag);
    check($sformatf("%s_out", tag), 32'(output_number), 32'(m_out));
    check($sformatf("%s_sel", tag), 32'(selcted_number), 32'(exp_sel()));
    check($sformatf("%s_fsm", tag), 32'(dut.state), m_started ? 32'd1 : 32'd0);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s_mem%0d", tag, i), 32'(dut.mem[i]), 32'(m_mem[i]));
  endtask

  initial begin
    logic [7:0] card;
    logic [7:0] miss;
    int d;
    key_on = 0; key_row = 4'b1000; key_col = 3'b000;
    hack_number = 8'h00; load_hack = 0; player_sel = 0; next = 0;
    rstn = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_rows", 32'(keyboard_rows), 32'h8);
    check_outputs("rst");
    rstn = 1'b0;

    @(negedge clk); check("scan1", 32'(keyboard_rows), 32'h4);
    @(negedge clk); check("scan2", 32'(keyboard_rows), 32'h2);
    @(negedge clk); check("scan3", 32'(keyboard_rows), 32'h1);
    @(negedge clk); check("scan4", 32'(keyboard_rows), 32'h8);

    // a random first digit then A discards the partial entry
    d = $urandom_range(1, 9);
    press(d);
    check("partial_sel", 32'(selcted_number), 32'(exp_sel()));
    press(10);
    check("clear_sel", 32'(selcted_number), 32'(exp_sel()));

    for (int i = 0; i < 16; i++) begin
      card = (i < 8) ? 8'(i + 1) : 8'(8'h11 + (i - 8));
      press(int'(card[7:4]));
      press(int'(card[3:0]));
      if (i == 4) begin
        press(11);
        check("early_b_start", 32'(dut.start_game), 32'd0);
        check_outputs("early_b");
      end
    end
    check_mem("entry");

    press(d);
    check("full_digit_ignored_sel", 32'(selcted_number), 32'(exp_sel()));
    press(10);
    press(11);
    check("start_flag", 32'(dut.start_game), 32'd1);
    check_outputs("start");
    player_sel = 1'b1;
    @(negedge clk);
    check("start_p2_sel", 32'(selcted_number), 32'(exp_sel()));
    player_sel = 1'b0;

    press(5);
    check_mem("post_start_key");

    for (int k = 1; k <= 8; k++) begin
      if (k == 4) begin
        draw(8'h99);
        check_outputs("miss99");
        check_mem("miss99");
      end else if ($urandom_range(0, 1) == 1) begin
        miss = {4'($urandom_range(2, 9)), 4'($urandom_range(0, 9))};
        draw(miss);
        check_outputs($sformatf("miss_%0h", miss));
      end
      draw(8'(k));
      check_outputs($sformatf("hit%0d", k));
      check($sformatf("p1_count%0d", k), 32'($countones(selcted_number)), 32'(k));
    end
    check("endgame", 32'(dut.endgame), 32'd1);
    check("final_gs", 32'(dut.game_state), 32'h00FF);
    check_mem("end");

    draw(8'h11);
    check_outputs("after_end");
    check("after_end_gs", 32'(dut.game_state), 32'h00FF);

    player_sel = 1'b1;
    @(negedge clk);
    check("end_p2_sel", 32'(selcted_number), 32'(exp_sel()));

    // reset in the middle of a draw attempt
    next = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    next = 1'b0;
    check("mid_rst_rows", 32'(keyboard_rows), 32'h8);
    check_outputs("mid_rst");
    check("mid_rst_gs", 32'(dut.game_state), 32'h0000);
    check_mem("mid_rst");
    rstn = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter DEBOUNCE_COUNT, default 100000: consecutive stable cycles required to accept a key press or release.
REQ-002 Parameter HOLD_COUNT, default 50000000: cycles the FSM dwells in HOLD after each draw.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rstn  input  1  asynchronous, active-high reset (asserted when 1, despite the name).
REQ-005 keyboard_cols  input  3  keypad columns; bit2 = left, bit0 = right; 1 = key pressed in the currently driven row.
REQ-006 hack_number  input  8  BCD number used as the draw when load_hack = 1.
REQ-007 load_hack  input  1  1 selects hack_number instead of the PRNG for draws.
REQ-008 player_sel  input  1  after start, selects the player bitmap shown on selcted_number (0 = P1, 1 = P2).
REQ-009 next  input  1  draw request; acted on at its rising edge.
REQ-010 keyboard_rows  output  4  one-hot keypad row drive; bit3 = top row.
REQ-011 selcted_number  output  8  entry phase: number being typed {d1,d2}; after start: marked bitmap of the selected player.
REQ-012 output_number  output  8  last drawn number.

Function
REQ-013 Keypad map, by row then cols 100/010/001:
- 1000 → 1,2,3
- 0100 → 4,5,6
- 0010 → 7,8,9
- 0001 → A, 0, B
REQ-014 Row scanning and key registration:
- Row drive rotates 1000→0100→0010→0001→1000 one step per cycle while keyboard_cols == 000.
- Row freezes while any column is high.
REQ-015 A key registers exactly once, after keyboard_cols has been stable and non-zero for DEBOUNCE_COUNT cycles; the next key registers only after cols are 000 for DEBOUNCE_COUNT cycles.
REQ-016 Entry phase (before start), per digit key 0-9:
- First digit → d1 (high nibble); second digit → d2 (low nibble).
- On the second digit, {d1,d2} is written to mem[wr_ptr] and wr_ptr increments.
- The partial entry then clears.
REQ-017 Memory holds 16 × 8-bit entries:
- Entries 0-7 = Player 1 card; entries 8-15 = Player 2 card.
- Digits are ignored once wr_ptr reaches 16 (no wrap).
REQ-018 Key A clears a partial entry. Key B sets start_game only when all 16 entries are written; otherwise B is ignored. After start, all keys are ignored.
REQ-019 PRNG is an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1:
- Seeded 8'h01 on reset; advances every cycle.
- Draw value = each nibble, minus 6 if the nibble ≥ 10 (always valid BCD).
REQ-020 FSM encoding and transitions:
- START=0: wait for start_game, then → IDLE.
- IDLE=1: wait for a rising edge of next (registered one cycle) with endgame = 0, then → DRAW.
- DRAW=2 (1 cycle): number = load_hack ? hack_number : PRNG value; output_number is updated.
- SCAN=3 (16 cycles): checks index 0..15, one index per cycle.
- HOLD=4: HOLD_COUNT cycles, then → IDLE.
REQ-021 Match rule in SCAN: if mem[i] == number and game_state[i] == 0, then mem[i] ← 8'h00 and game_state[i] ← 1. All matches are marked, duplicates included.
REQ-022 endgame:
- Sets at the HOLD→IDLE transition if game_state[7:0] == 8'hFF (P1 wins) or game_state[15:8] == 8'hFF (P2 wins).
- Remains set until reset; next is ignored while endgame = 1.
REQ-023 A next edge arriving outside IDLE is discarded. A draw with no match leaves memory and game_state unchanged.

Reset
REQ-024 Reset clears the following:
- keyboard_rows = 1000, wr_ptr = 0, d1 = d2 = 0.
- All mem entries = 00, start_game = 0, FSM = START.
- game_state = 0, endgame = 0, output_number = 00, selcted_number = 00, LFSR = 01.
REQ-025 Reset mid-game returns the block to the entry phase with an empty card.

Verification (DEBOUNCE_COUNT=20, HOLD_COUNT=50; key hold/release 300 cycles)
REQ-026 Key entry: enter 0,1,0,2,…,0,8 then 1,1,…,1,8 → mem[0..7] = 01..08, mem[8..15] = 11..18.
REQ-027 Start: press B after 16 entries → start_game = 1, FSM = 1, game_state = 0. Pressing B with fewer than 16 entries → no start.
REQ-028 Hack draws: load_hack = 1; draw hack_number 01..08 in turn via next pulses. After each draw the FSM returns to state 1 and P1 popcount increments 1..8. Final game_state = 16'h00FF, endgame = 1.
REQ-029 End check: mem[0..7] = 00; mem[8..15] = 11..18 unchanged. A further next pulse leaves FSM in state 1 with output_number unchanged.
REQ-030 Miss: draw 99 → game_state and memory unchanged; output_number = 99.
REQ-031 player_sel = 1 after start → selcted_number = game_state[15:8]; reset asserted mid-game → all outputs return to their REQ-024 values.
